// File: rtl/axis_frame_arbiter.sv
// Frame-aware round-robin arbiter that funnels PORTS AXI-stream sources into one
// output register feeding the async FIFO write port; a grant is held until tlast.
module axis_frame_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    localparam int GW        = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        async_rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] in_axis_tdata,
    input  logic [PORTS-1:0]            in_axis_tvalid,
    output logic [PORTS-1:0]            in_axis_tready,
    input  logic [PORTS-1:0]            in_axis_tlast,
    input  logic [PORTS-1:0]            in_axis_tuser,
    output logic [DATA_WIDTH-1:0]       output_axis_tdata,
    output logic                        output_axis_tvalid,
    input  logic                        output_axis_tready,
    output logic                        output_axis_tlast,
    output logic                        output_axis_tuser,
    output logic                        grant_valid,
    output logic [GW-1:0]               grant_index
);

    localparam int SW = GW + 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         lastGrant_q, lastGrant_d;
    logic [GW-1:0]         grantIdx_q, grantIdx_d;
    logic                  grantValid_q, grantValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  outLast_q, outLast_d;
    logic                  outUser_q, outUser_d;
    logic                  outValid_q, outValid_d;

    logic                  found;
    logic [GW-1:0]         winner;
    logic [SW-1:0]         cand;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selValid;
    logic                  selLast;
    logic                  selUser;
    logic                  outReady;
    logic                  beatAccept;

    // Scan starts one past the previous winner so every source waits at most PORTS-1 frames.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = {1'b0, lastGrant_q} + SW'(k);
            if (cand >= SW'(PORTS)) begin
                cand = cand - SW'(PORTS);
            end
            if (!found && in_axis_tvalid[cand[GW-1:0]]) begin
                found  = 1'b1;
                winner = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selLast  = 1'b0;
        selUser  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grantIdx_q == GW'(i)) begin
                selData  = in_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                selValid = in_axis_tvalid[i];
                selLast  = in_axis_tlast[i];
                selUser  = in_axis_tuser[i];
            end
        end
    end

    assign outReady   = output_axis_tready | ~outValid_q;
    assign beatAccept = (state_q == ACTIVE) & selValid & outReady;

    always_comb begin
        in_axis_tready = '0;
        if (state_q == ACTIVE) begin
            for (int i = 0; i < PORTS; i++) begin
                if (grantIdx_q == GW'(i)) begin
                    in_axis_tready[i] = outReady;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        grantIdx_d   = grantIdx_q;
        grantValid_d = grantValid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grantIdx_d   = winner;
                    grantValid_d = 1'b1;
                    state_d      = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beatAccept && selLast) begin
                    lastGrant_d  = grantIdx_q;
                    grantValid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data bits are deliberately held after the FIFO drains the beat; only valid clears.
    always_comb begin
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outUser_d  = outUser_q;
        outValid_d = outValid_q;
        if (beatAccept) begin
            outData_d  = selData;
            outLast_d  = selLast;
            outUser_d  = selUser;
            outValid_d = 1'b1;
        end else if (output_axis_tready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q      <= IDLE;
            lastGrant_q  <= GW'(PORTS - 1);
            grantIdx_q   <= '0;
            grantValid_q <= 1'b0;
            outData_q    <= '0;
            outLast_q    <= 1'b0;
            outUser_q    <= 1'b0;
            outValid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            grantIdx_q   <= grantIdx_d;
            grantValid_q <= grantValid_d;
            outData_q    <= outData_d;
            outLast_q    <= outLast_d;
            outUser_q    <= outUser_d;
            outValid_q   <= outValid_d;
        end
    end

    assign output_axis_tdata  = outData_q;
    assign output_axis_tvalid = outValid_q;
    assign output_axis_tlast  = outLast_q;
    assign output_axis_tuser  = outUser_q;
    assign grant_valid        = grantValid_q;
    assign grant_index        = grantIdx_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: a source driver feeds queued frames, a
// monitor pops expected beats/grants as the DUT presents them.
module tb_axis_frame_arbiter;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
        logic       user;
    } srcBeat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } expBeat_t;

    logic        clk;
    logic        async_rst_n;
    logic [31:0] in_axis_tdata;
    logic [3:0]  in_axis_tvalid;
    logic [3:0]  in_axis_tready;
    logic [3:0]  in_axis_tlast;
    logic [3:0]  in_axis_tuser;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready;
    logic        output_axis_tlast;
    logic        output_axis_tuser;
    logic        grant_valid;
    logic [1:0]  grant_index;

    srcBeat_t    pend[$];
    expBeat_t    expQ[$];
    logic [1:0]  grantQ[$];
    int          checkCount = 0;
    int          passCount  = 0;

    axis_frame_arbiter #(.PORTS(4), .DATA_WIDTH(8)) dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .in_axis_tdata      (in_axis_tdata),
        .in_axis_tvalid     (in_axis_tvalid),
        .in_axis_tready     (in_axis_tready),
        .in_axis_tlast      (in_axis_tlast),
        .in_axis_tuser      (in_axis_tuser),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .output_axis_tuser  (output_axis_tuser),
        .grant_valid        (grant_valid),
        .grant_index        (grant_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] firstData, input int len, input logic lastUser);
        srcBeat_t b;
        for (int i = 0; i < len; i++) begin
            b.src  = 2'(src);
            b.data = firstData + 8'(i);
            b.last = (i == len - 1);
            b.user = lastUser && (i == len - 1);
            pend.push_back(b);
        end
    endtask

    task automatic expectFrame(input logic [7:0] firstData, input int len, input logic lastUser);
        expBeat_t e;
        for (int i = 0; i < len; i++) begin
            e.data = firstData + 8'(i);
            e.last = (i == len - 1);
            e.user = lastUser && (i == len - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic removeHead(input int s);
        for (int i = 0; i < pend.size(); i++) begin
            if (int'(pend[i].src) == s) begin
                pend.delete(i);
                break;
            end
        end
    endtask

    task automatic presentHeads();
        logic [31:0] td;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [3:0]  tu;
        td = '0;
        tv = '0;
        tl = '0;
        tu = '0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < pend.size(); i++) begin
                if (!tv[s] && int'(pend[i].src) == s) begin
                    tv[s]        = 1'b1;
                    td[s*8 +: 8] = pend[i].data;
                    tl[s]        = pend[i].last;
                    tu[s]        = pend[i].user;
                end
            end
        end
        in_axis_tdata  = td;
        in_axis_tvalid = tv;
        in_axis_tlast  = tl;
        in_axis_tuser  = tu;
    endtask

    task automatic waitDrain(input string name);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            idle = (expQ.size() == 0) && (grantQ.size() == 0) && (pend.size() == 0) &&
                   !grant_valid && !output_axis_tvalid;
            if (idle) break;
            tick(1);
        end
        checkOutput(name, 32'(idle), 32'd1);
    endtask

    task automatic doReset();
        async_rst_n = 1'b0;
        tick(2);
        async_rst_n = 1'b1;
    endtask

    // Source driver: handshakes are sampled at the falling edge, heads advance after the rising edge.
    initial begin
        logic [3:0] acc;
        in_axis_tdata  = '0;
        in_axis_tvalid = '0;
        in_axis_tlast  = '0;
        in_axis_tuser  = '0;
        forever begin
            @(negedge clk);
            acc = in_axis_tvalid & in_axis_tready;
            @(posedge clk);
            #1;
            for (int s = 0; s < 4; s++) begin
                if (acc[s]) removeHead(s);
            end
            presentHeads();
        end
    end

    initial begin
        logic     gvPrev;
        expBeat_t e;
        logic [1:0] g;
        gvPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (async_rst_n) begin
                if (output_axis_tvalid && output_axis_tready) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL beat: unexpected data 0x%0h, expected none", output_axis_tdata);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat", 32'({output_axis_tlast, output_axis_tuser, output_axis_tdata}),
                                    32'({e.last, e.user, e.data}));
                    end
                end
                if (grant_valid && !gvPrev) begin
                    if (grantQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL grant: unexpected grant %0d, expected none", grant_index);
                    end else begin
                        g = grantQ.pop_front();
                        checkOutput("grant", 32'(grant_index), 32'(g));
                    end
                end
            end
            gvPrev = grant_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        async_rst_n        = 1'b0;
        output_axis_tready = 1'b1;
        #2;
        checkOutput("rst grant_valid", 32'(grant_valid), 32'd0);
        checkOutput("rst grant_index", 32'(grant_index), 32'd0);
        checkOutput("rst out tvalid", 32'(output_axis_tvalid), 32'd0);
        checkOutput("rst out bits", 32'({output_axis_tlast, output_axis_tuser, output_axis_tdata}), 32'd0);
        checkOutput("rst in tready", 32'(in_axis_tready), 32'd0);
        @(posedge clk);
        #3;
        tick(1);
        async_rst_n = 1'b1;

        $display("[TB] single source");
        applyStimulus(2, 8'hA1, 3, 1'b0);
        expectFrame(8'hA1, 3, 1'b0);
        grantQ.push_back(2'd2);
        tick(2);
        checkOutput("t1 grant_valid", 32'(grant_valid), 32'd1);
        checkOutput("t1 grant_index", 32'(grant_index), 32'd2);
        checkOutput("t1 tready", 32'(in_axis_tready), 32'h4);
        checkOutput("t1 no early beat", 32'(output_axis_tvalid), 32'd0);
        tick(1);
        checkOutput("t1 first beat", 32'({output_axis_tvalid, output_axis_tdata}), 32'h1A1);
        tick(2);
        checkOutput("t1 last beat", 32'({output_axis_tlast, output_axis_tdata}), 32'h1A3);
        tick(1);
        checkOutput("t1 released", 32'({grant_valid, output_axis_tvalid}), 32'd0);
        waitDrain("t1 drain");

        $display("[TB] contention");
        doReset();
        applyStimulus(0, 8'h10, 2, 1'b0);
        applyStimulus(1, 8'h20, 2, 1'b0);
        expectFrame(8'h10, 2, 1'b0);
        expectFrame(8'h20, 2, 1'b0);
        grantQ.push_back(2'd0);
        grantQ.push_back(2'd1);
        tick(4);
        checkOutput("t2 src0 last", 32'({output_axis_tlast, output_axis_tdata}), 32'h111);
        tick(1);
        checkOutput("t2 idle gap", 32'(output_axis_tvalid), 32'd0);
        checkOutput("t2 second grant", 32'({grant_valid, grant_index}), 32'h5);
        waitDrain("t2 drain");

        $display("[TB] fairness");
        doReset();
        applyStimulus(0, 8'h30, 1, 1'b0);
        applyStimulus(0, 8'h34, 1, 1'b0);
        applyStimulus(1, 8'h31, 1, 1'b0);
        applyStimulus(1, 8'h35, 1, 1'b0);
        applyStimulus(2, 8'h32, 1, 1'b0);
        applyStimulus(3, 8'h33, 1, 1'b0);
        for (int i = 0; i < 6; i++) expectFrame(8'h30 + 8'(i), 1, 1'b0);
        grantQ.push_back(2'd0);
        grantQ.push_back(2'd1);
        grantQ.push_back(2'd2);
        grantQ.push_back(2'd3);
        grantQ.push_back(2'd0);
        grantQ.push_back(2'd1);
        tick(3);
        for (int i = 0; i < 11; i++) begin
            checkOutput("t3 cadence", 32'(output_axis_tvalid), 32'((i % 2) == 0));
            tick(1);
        end
        waitDrain("t3 drain");

        $display("[TB] backpressure and sideband");
        applyStimulus(3, 8'h40, 4, 1'b1);
        expectFrame(8'h40, 4, 1'b1);
        grantQ.push_back(2'd3);
        tick(4);
        output_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("t4 hold", 32'({output_axis_tvalid, output_axis_tdata}), 32'h141);
            checkOutput("t4 tready low", 32'(in_axis_tready), 32'd0);
        end
        output_axis_tready = 1'b1;
        tick(1);
        checkOutput("t4 resume", 32'(output_axis_tdata), 32'h42);
        tick(2);
        checkOutput("t4 tuser+tlast", 32'({output_axis_tlast, output_axis_tuser, output_axis_tdata}), 32'h343);
        waitDrain("t4 drain");

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h5F, 1, 1'b0);
        expectFrame(8'h5F, 1, 1'b0);
        grantQ.push_back(2'd0);
        waitDrain("t5 pre drain");
        applyStimulus(1, 8'h60, 4, 1'b0);
        expectFrame(8'h60, 4, 1'b0);
        grantQ.push_back(2'd1);
        tick(4);
        checkOutput("t5 beat2 shown", 32'(output_axis_tdata), 32'h61);
        async_rst_n = 1'b0;
        #1;
        checkOutput("t5 out cleared", 32'({output_axis_tvalid, output_axis_tlast, output_axis_tuser, output_axis_tdata}), 32'd0);
        checkOutput("t5 grant cleared", 32'({grant_valid, grant_index}), 32'd0);
        checkOutput("t5 tready cleared", 32'(in_axis_tready), 32'd0);
        pend.delete();
        expQ.delete();
        grantQ.delete();
        applyStimulus(0, 8'h70, 1, 1'b0);
        applyStimulus(1, 8'h71, 1, 1'b0);
        expectFrame(8'h70, 1, 1'b0);
        expectFrame(8'h71, 1, 1'b0);
        grantQ.push_back(2'd0);
        grantQ.push_back(2'd1);
        tick(2);
        async_rst_n = 1'b1;
        waitDrain("t5 drain");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
